// File: rtl/display_panel_receiver_if.sv
// Record stream from the panel receiver: one beat per oe pulse, valid/ready handshake.
interface display_panel_receiver_if #(
  parameter int RW       = 3,
  parameter int COLUMNS  = 32,
  parameter int DATAW    = 6,
  parameter int ONTIME_W = 16
);
  logic                       out_valid;
  logic                       out_ready;
  logic [RW-1:0]              out_row;
  logic [COLUMNS*DATAW-1:0]   out_data;
  logic [ONTIME_W-1:0]        out_ontime;
  logic                       out_shift_err;

  modport master (
    output out_valid, out_row, out_data, out_ontime, out_shift_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_row, out_data, out_ontime, out_shift_err,
    output out_ready
  );
endinterface

// File: rtl/display_panel_receiver.sv
// HUB75-style panel receiver: oversamples oclk/lat/oe/row/data, emits one record per oe pulse.
// DISPLAY_RX_PASSTHROUGH_EN adds aligned q_* outputs for chained-panel emulation.
module display_panel_receiver #(
  parameter  int ROWS        = 8,
  parameter  int COLUMNS     = 32,
  parameter  int DATAW       = 6,
  parameter  int ONTIME_W    = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int RW          = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_oclk,
  input  logic                 p_lat,
  input  logic                 p_oe,
  input  logic [RW-1:0]        p_row,
  input  logic [DATAW-1:0]     p_data,
  display_panel_receiver_if.master rec,
  output logic                 overflow
`ifdef DISPLAY_RX_PASSTHROUGH_EN
  ,
  output logic                 q_oclk,
  output logic                 q_lat,
  output logic                 q_oe,
  output logic [RW-1:0]        q_row,
  output logic [DATAW-1:0]     q_data
`endif
);

  localparam int SW  = 3 + RW + DATAW;
  localparam int SRW = COLUMNS * DATAW;
  localparam int CW  = $clog2(COLUMNS + 2);
  // Idle pin levels so reset release never looks like an edge.
  localparam logic [SW-1:0] IDLE_VEC = {1'b0, 1'b1, 1'b1, {RW{1'b0}}, {DATAW{1'b0}}};

  typedef enum logic {IDLE, LIT} state_t;

  logic [SW-1:0]       sync_q [SYNC_STAGES];
  logic                s_oclk, s_lat, s_oe;
  logic [RW-1:0]       s_row;
  logic [DATAW-1:0]    s_data;
  logic                h_oclk, h_lat, h_oe;
  logic                oclk_rise, lat_fall, oe_fall, oe_rise;

  logic [SRW-1:0]      sreg, sreg_nx, latch_q, latch_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                lerr_q, lerr_nx;

  state_t              state, state_nx;
  logic                start, finish;
  logic [RW-1:0]       row_q;
  logic [ONTIME_W-1:0] ontime;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_VEC;
      h_oclk <= 1'b0;
      h_lat  <= 1'b1;
      h_oe   <= 1'b1;
    end else begin
      sync_q[0] <= {p_oclk, p_lat, p_oe, p_row, p_data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      h_oclk <= s_oclk;
      h_lat  <= s_lat;
      h_oe   <= s_oe;
    end
  end

  assign {s_oclk, s_lat, s_oe, s_row, s_data} = sync_q[SYNC_STAGES-1];
  assign oclk_rise = s_oclk & ~h_oclk;
  assign lat_fall  = ~s_lat & h_lat;
  assign oe_fall   = ~s_oe & h_oe;
  assign oe_rise   = s_oe & ~h_oe;

  // A shift in the same cycle as a latch is applied first, so the latch sees it.
  always_comb begin
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    latch_nx = latch_q;
    lerr_nx  = lerr_q;
    if (oclk_rise) begin
      sreg_nx = {s_data, sreg[SRW-1:DATAW]};
      if (cnt != CW'(COLUMNS + 1)) cnt_nx = cnt + CW'(1);
    end
    if (lat_fall) begin
      latch_nx = sreg_nx;
      lerr_nx  = (cnt_nx != CW'(COLUMNS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      latch_q <= '0;
      lerr_q  <= 1'b0;
    end else begin
      sreg    <= sreg_nx;
      cnt     <= lat_fall ? '0 : cnt_nx;
      latch_q <= latch_nx;
      lerr_q  <= lerr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: if (oe_fall) begin
        start    = 1'b1;
        state_nx = LIT;
      end
      LIT: if (oe_rise) begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      ontime <= '0;
    end else if (start) begin
      row_q  <= s_row;
      ontime <= ONTIME_W'(1);
    end else if (state == LIT && !s_oe && ontime != '1) begin
      ontime <= ontime + ONTIME_W'(1);
    end
  end

  // Single output slot: a record arriving while the slot is stuck is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec.out_valid     <= 1'b0;
      rec.out_row       <= '0;
      rec.out_data      <= '0;
      rec.out_ontime    <= '0;
      rec.out_shift_err <= 1'b0;
      overflow          <= 1'b0;
    end else if (finish) begin
      if (!rec.out_valid || rec.out_ready) begin
        rec.out_valid     <= 1'b1;
        rec.out_row       <= row_q;
        rec.out_data      <= latch_nx;
        rec.out_ontime    <= ontime;
        rec.out_shift_err <= lerr_nx;
      end else begin
        overflow <= 1'b1;
      end
    end else if (rec.out_ready) begin
      rec.out_valid <= 1'b0;
    end
  end

`ifdef DISPLAY_RX_PASSTHROUGH_EN
  logic [RW-1:0]    h_row;
  logic [DATAW-1:0] q_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_row    <= '0;
      q_data_q <= '0;
    end else begin
      h_row <= s_row;
      if (oclk_rise) q_data_q <= sreg[DATAW-1:0];
    end
  end

  assign q_oclk = h_oclk;
  assign q_lat  = h_lat;
  assign q_oe   = h_oe;
  assign q_row  = h_row;
  assign q_data = q_data_q;
`endif

endmodule
